// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: flags each occurrence of an N-bit PATTERN on a strobed serial stream
module serial_pattern_detector #(
  parameter int N = 3,
  parameter logic [N-1:0] PATTERN = 3'b110,
  parameter bit OVERLAP = 1'b1,
  parameter int COUNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic x_valid,
  input  logic x,
  output logic y,
  output logic primed,
  output logic [COUNT_W-1:0] match_count
);
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(N);
  logic [N-1:0] hist, hist_n;
  logic [FW-1:0] fill, fill_n;
  logic match;
  always_comb begin
    hist_n = {hist[N-2:0], x};
    fill_n = (fill == FILL_MAX) ? fill : fill + 1'b1;
    match = x_valid && (fill_n == FILL_MAX) && (hist_n == PATTERN);
  end
  // Non-overlap mode empties the fill level so the next match needs N fresh bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
      y <= 1'b0;
      match_count <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
      y <= 1'b0;
      match_count <= '0;
    end else begin
      y <= match;
      if (x_valid) begin
        hist <= hist_n;
        fill <= (match && !OVERLAP) ? '0 : fill_n;
        if (match && !(&match_count)) match_count <= match_count + 1'b1;
      end
    end
  end
  assign primed = (fill == FILL_MAX);
endmodule
